// File: rtl/pcmcia_host_cycle.sv
// rtl/pcmcia_host_cycle.sv - host-side PC Card / CF 8-bit bus cycle initiator
module pcmcia_host_cycle #(
    parameter int T_SETUP      = 2,
    parameter int T_STROBE     = 8,
    parameter int T_HOLD       = 2,
    parameter int WAIT_TIMEOUT = 1024,
    parameter int CNT_W        = 11
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_space,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_timeout,
    output logic        rsp_inpack,
    output logic [15:0] A,
    output logic [7:0]  D_out,
    output logic        D_oe,
    input  logic [7:0]  D_in,
    output logic        CE1,
    output logic        CE2,
    output logic        REG,
    output logic        OE,
    output logic        WE,
    output logic        IORD,
    output logic        IOWR,
    input  logic        WAIT,
    input  logic        INPACK
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_HOLD   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [1:0] SP_COMMON = 2'b00;
    localparam logic [1:0] SP_IO     = 2'b10;
    localparam logic [1:0] SP_RSVD   = 2'b11;

    localparam logic [CNT_W-1:0] SETUP_N   = CNT_W'(T_SETUP);
    localparam logic [CNT_W-1:0] STROBE_N  = CNT_W'(T_STROBE);
    localparam logic [CNT_W-1:0] HOLD_N    = CNT_W'(T_HOLD);
    localparam logic [CNT_W-1:0] TIMEOUT_N = CNT_W'(WAIT_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [2:0]       state;
    logic [2:0]       next_state;
    logic [CNT_W-1:0] cnt;
    logic             wait_meta;
    logic             wait_s;
    logic             inpack_meta;
    logic             inpack_s;
    logic             lat_write;
    logic [1:0]       lat_space;
    logic [7:0]       rd_cap;
    logic             to_flag;
    logic             ip_flag;
    logic             accept;
    logic             strobe_done;
    logic             strobe_abort;

    assign accept       = (state == S_IDLE) && req_ready && req_valid;
    assign strobe_done  = (cnt >= STROBE_N) && wait_s;
    assign strobe_abort = !strobe_done && (cnt >= TIMEOUT_N);
    assign CE2          = 1'b1;

    // WAIT# and INPACK# come straight from the card pins
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wait_meta   <= 1'b1;
            wait_s      <= 1'b1;
            inpack_meta <= 1'b1;
            inpack_s    <= 1'b1;
        end else begin
            wait_meta   <= WAIT;
            wait_s      <= wait_meta;
            inpack_meta <= INPACK;
            inpack_s    <= inpack_meta;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (accept) next_state = (req_space == SP_RSVD) ? S_DONE : S_SETUP;
            S_SETUP:  if (cnt >= SETUP_N) next_state = S_STROBE;
            S_STROBE: if (strobe_done || strobe_abort) next_state = S_HOLD;
            S_HOLD:   if (cnt >= HOLD_N) next_state = S_DONE;
            S_DONE:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= S_IDLE;
            cnt         <= '0;
            req_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 8'h00;
            rsp_timeout <= 1'b0;
            rsp_inpack  <= 1'b0;
            A           <= 16'h0000;
            D_out       <= 8'h00;
            D_oe        <= 1'b0;
            CE1         <= 1'b1;
            REG         <= 1'b1;
            OE          <= 1'b1;
            WE          <= 1'b1;
            IORD        <= 1'b1;
            IOWR        <= 1'b1;
            lat_write   <= 1'b0;
            lat_space   <= SP_COMMON;
            rd_cap      <= 8'h00;
            to_flag     <= 1'b0;
            ip_flag     <= 1'b0;
        end else begin
            state     <= next_state;
            req_ready <= (next_state == S_IDLE);
            rsp_valid <= 1'b0;

            // cnt reads 1 in the first cycle of every state, saturating afterwards
            if (next_state != state)
                cnt <= CNT_ONE;
            else if (cnt != CNT_MAX)
                cnt <= cnt + CNT_ONE;

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        lat_write <= req_write;
                        lat_space <= req_space;
                        to_flag   <= 1'b0;
                        ip_flag   <= 1'b0;
                        if (req_space != SP_RSVD) begin
                            A   <= req_addr;
                            REG <= (req_space == SP_COMMON);
                            CE1 <= 1'b0;
                            if (req_write) begin
                                D_out <= req_wdata;
                                D_oe  <= 1'b1;
                            end
                        end
                    end
                end
                S_SETUP: begin
                    if (next_state == S_STROBE) begin
                        if (lat_space == SP_IO) begin
                            IORD <= lat_write;
                            IOWR <= !lat_write;
                        end else begin
                            OE <= lat_write;
                            WE <= !lat_write;
                        end
                    end
                end
                S_STROBE: begin
                    rd_cap <= D_in;
                    if (lat_space == SP_IO && !lat_write && !inpack_s)
                        ip_flag <= 1'b1;
                    if (next_state == S_HOLD) begin
                        OE   <= 1'b1;
                        WE   <= 1'b1;
                        IORD <= 1'b1;
                        IOWR <= 1'b1;
                        if (strobe_abort)
                            to_flag <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (next_state == S_DONE) begin
                        CE1  <= 1'b1;
                        REG  <= 1'b1;
                        D_oe <= 1'b0;
                    end
                end
                S_DONE: begin
                    rsp_valid   <= 1'b1;
                    rsp_timeout <= to_flag;
                    rsp_inpack  <= ip_flag;
                    if (lat_space == SP_RSVD || to_flag)
                        rsp_rdata <= 8'hFF;
                    else if (!lat_write)
                        rsp_rdata <= rd_cap;
                    else
                        rsp_rdata <= 8'h00;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pcmcia_host_cycle.sv
// tb/tb_pcmcia_host_cycle.sv - self-checking bench for pcmcia_host_cycle
module tb_pcmcia_host_cycle;

    localparam int T_SETUP      = 2;
    localparam int T_STROBE     = 8;
    localparam int T_HOLD       = 2;
    localparam int WAIT_TIMEOUT = 1024;

    logic        CLK;
    logic        RESET;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_space;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_timeout;
    logic        rsp_inpack;
    logic [15:0] A;
    logic [7:0]  D_out;
    logic        D_oe;
    logic [7:0]  D_in;
    logic        CE1, CE2, REG, OE, WE, IORD, IOWR;
    logic        WAIT;
    logic        INPACK;

    int n_tests = 0;
    int n_fail  = 0;
    int rsp_seen;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    pcmcia_host_cycle #(
        .T_SETUP(T_SETUP), .T_STROBE(T_STROBE), .T_HOLD(T_HOLD),
        .WAIT_TIMEOUT(WAIT_TIMEOUT), .CNT_W(11)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_space(req_space), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_timeout(rsp_timeout), .rsp_inpack(rsp_inpack),
        .A(A), .D_out(D_out), .D_oe(D_oe), .D_in(D_in),
        .CE1(CE1), .CE2(CE2), .REG(REG), .OE(OE), .WE(WE),
        .IORD(IORD), .IOWR(IOWR), .WAIT(WAIT), .INPACK(INPACK)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Strobe cycle j exits once j >= T_STROBE and the WAIT level seen (two cycles stale) is high
    task automatic model_strobe(input int wlow, output int len, output bit to);
        len = WAIT_TIMEOUT;
        to  = 1'b1;
        for (int j = T_STROBE; j <= WAIT_TIMEOUT; j++) begin
            if (!((j - 2) >= 1 && (j - 2) <= wlow)) begin
                len = j;
                to  = 1'b0;
                break;
            end
        end
    endtask

    task automatic run_txn(input string tag, input bit wr, input logic [1:0] sp,
                           input logic [15:0] addr, input logic [7:0] wd, input logic [7:0] rd,
                           input int wlow, input bit ip_low, input bit hold_valid);
        int len, c, c_rsp, guard, j, sel, exp_lat, exp_ce;
        int st_n[4];
        int ce1_n, ce2_n, reg_n, doe_n, excl_bad, busy_ready, a_bad, dout_bad;
        bit to, exp_ip;
        logic [7:0] exp_rd;

        if (sp == 2'b11) begin
            len = 0;
            to  = 1'b0;
        end else begin
            model_strobe(wlow, len, to);
        end
        exp_lat = (sp == 2'b11) ? 1 : 1 + T_SETUP + len + T_HOLD;
        exp_ce  = (sp == 2'b11) ? 0 : T_SETUP + len + T_HOLD;
        sel     = (sp == 2'b10) ? (wr ? 3 : 2) : (wr ? 1 : 0);
        exp_ip  = (sp == 2'b10) && !wr && ip_low;
        exp_rd  = (sp == 2'b11 || to) ? 8'hFF : rd;
        for (int k = 0; k < 4; k++) st_n[k] = 0;
        ce1_n = 0; ce2_n = 0; reg_n = 0; doe_n = 0;
        excl_bad = 0; busy_ready = 0; a_bad = 0; dout_bad = 0;

        guard = 0;
        while (req_ready !== 1'b1 && guard < 2000) begin
            @(negedge CLK);
            guard++;
        end
        check({tag, ".ready"}, req_ready, 1);
        check({tag, ".ce1_idle"}, CE1, 1);
        req_write = wr;
        req_space = sp;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        @(posedge CLK);

        c = 0;
        c_rsp = 0;
        while (c_rsp == 0 && c < 3000) begin
            @(negedge CLK);
            c++;
            if (!hold_valid) req_valid = 1'b0;
            if (rsp_valid) begin
                c_rsp = c;
            end else begin
                if (req_ready) busy_ready++;
                if (!OE)   st_n[0]++;
                if (!WE)   st_n[1]++;
                if (!IORD) st_n[2]++;
                if (!IOWR) st_n[3]++;
                if (!CE1)  ce1_n++;
                if (!CE2)  ce2_n++;
                if (!REG)  reg_n++;
                if (D_oe)  doe_n++;
                if (int'(!OE) + int'(!WE) + int'(!IORD) + int'(!IOWR) > 1) excl_bad++;
                if (!CE1 && A !== addr) a_bad++;
                if (D_oe && D_out !== wd) dout_bad++;
            end
            j = c - 2;
            WAIT   = (j >= 1 && j <= wlow) ? 1'b0 : 1'b1;
            INPACK = (ip_low && j >= 1 && j <= len) ? 1'b0 : 1'b1;
            D_in   = (j == len) ? rd : 8'($urandom);
        end
        WAIT   = 1'b1;
        INPACK = 1'b1;

        check({tag, ".rsp_seen"}, c_rsp != 0, 1);
        check({tag, ".latency"}, c_rsp - 1, exp_lat);
        check({tag, ".strobe"}, st_n[sel], len);
        check({tag, ".strobe_total"}, st_n[0] + st_n[1] + st_n[2] + st_n[3], len);
        check({tag, ".ce1"}, ce1_n, exp_ce);
        check({tag, ".ce2"}, ce2_n, 0);
        check({tag, ".reg"}, reg_n, (sp == 2'b01 || sp == 2'b10) ? exp_ce : 0);
        check({tag, ".d_oe"}, doe_n, wr ? exp_ce : 0);
        check({tag, ".excl"}, excl_bad, 0);
        check({tag, ".busy_ready"}, busy_ready, 0);
        check({tag, ".addr"}, a_bad, 0);
        check({tag, ".dout"}, dout_bad, 0);
        check({tag, ".timeout"}, rsp_timeout, to);
        check({tag, ".inpack"}, rsp_inpack, exp_ip);
        if (!wr || sp == 2'b11) check({tag, ".rdata"}, rsp_rdata, exp_rd);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_space = 2'b00;
        req_addr  = 16'h0000;
        req_wdata = 8'h00;
        D_in      = 8'h00;
        WAIT      = 1'b1;
        INPACK    = 1'b1;

        repeat (3) @(negedge CLK);
        check("reset.ready", req_ready, 0);
        check("reset.rsp", {rsp_valid, rsp_timeout, rsp_inpack}, 0);
        check("reset.rdata", rsp_rdata, 0);
        check("reset.a", A, 0);
        check("reset.d", {D_out, D_oe}, 0);
        check("reset.ctl", {CE1, CE2, REG, OE, WE, IORD, IOWR}, 7'h7F);
        RESET = 1'b1;
        check("reset.ready_rel", req_ready, 0);
        @(negedge CLK);
        check("reset.ready_up", req_ready, 1);

        run_txn("attr_rd", 1'b0, 2'b01, 16'h0000, 8'h00, 8'h01, 0, 1'b0, 1'b0);
        run_txn("mem_wr", 1'b1, 2'b00, 16'h1234, 8'hA5, 8'h00, 0, 1'b0, 1'b0);
        run_txn("io_rd_wait", 1'b0, 2'b10, 16'h01F7, 8'h00, 8'h50, 20, 1'b1, 1'b0);
        run_txn("io_wr_stuck", 1'b1, 2'b10, 16'h0300, 8'h3C, 8'h00, 100000, 1'b0, 1'b0);
        run_txn("rsvd", 1'b0, 2'b11, 16'hBEEF, 8'h00, 8'h00, 0, 1'b0, 1'b0);

        // reset pulse while OE is low on an attribute read
        req_write = 1'b0;
        req_space = 2'b01;
        req_addr  = 16'h0040;
        req_valid = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        req_valid = 1'b0;
        repeat (4) @(negedge CLK);
        check("rst_mid.oe_before", OE, 0);
        #2 RESET = 1'b0;
        #1;
        check("rst_mid.oe", OE, 1);
        check("rst_mid.ce1", CE1, 1);
        check("rst_mid.reg", REG, 1);
        check("rst_mid.ready", req_ready, 0);
        check("rst_mid.a", A, 0);
        @(negedge CLK);
        RESET = 1'b1;
        check("rst_mid.ready_rel", req_ready, 0);
        @(negedge CLK);
        check("rst_mid.ready_up", req_ready, 1);
        rsp_seen = 0;
        repeat (16) begin
            @(negedge CLK);
            if (rsp_valid) rsp_seen++;
        end
        check("rst_mid.no_rsp", rsp_seen, 0);
        run_txn("after_rst", 1'b0, 2'b00, 16'h0077, 8'h00, 8'hC3, 3, 1'b0, 1'b0);

        run_txn("b2b_a", 1'b1, 2'b01, 16'h0200, 8'h5A, 8'h00, 0, 1'b0, 1'b1);
        run_txn("b2b_b", 1'b0, 2'b00, 16'h0201, 8'h00, 8'h96, 0, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            run_txn($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    16'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, 30)), 1'($urandom_range(0, 1)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
